// File: rtl/dc_pkg.sv
// Shared constants and state encoding for the rr_grant_idx arbiter and its
// downstream dc decoder.
package dc_pkg;

  // Default index width (N = 2**DEF_WIDTH requesters) and hold-counter width.
  localparam int unsigned DEF_WIDTH  = 2;
  localparam int unsigned DEF_HOLD_W = 8;

  // Arbiter state: no owner, or a grant is being held.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage : dc_pkg

// File: rtl/rr_grant_idx_pick.sv
// rr_pick: rotating-priority search. Returns the first requester at or after
// ptr (wrapping modulo N) and a flag saying whether any requester is active.
//   req : N-bit request vector
//   ptr : search start index
//   idx : selected index (0 when any=0)
//   any : at least one request bit is set
module rr_pick #(
  parameter int unsigned width = 2
) (
  input  logic [(1<<width)-1:0] req,
  input  logic [width-1:0]      ptr,
  output logic [width-1:0]      idx,
  output logic                  any
);

  localparam int unsigned N = 1 << width;

  logic [width-1:0] cand;

  // Walk ptr, ptr+1, ... with natural width-bit wrap; first hit wins.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 0; k < N; k++) begin
      cand = ptr + width'(k);
      if (!any && req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule : rr_pick

// File: rtl/rr_grant_idx.sv
// rr_grant_idx: round-robin arbiter producing a registered binary grant index
// and grant-valid that feed a one-hot decoder (dc.a / dc.Ena).
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request vector, bit i = requester i
//   done       : current owner releases the grant (only looked at while Ena=1)
//   a          : granted index (holds its value while idle)
//   Ena        : grant valid
//   Tout       : one-cycle pulse when the hold limit forced the release
module rr_grant_idx
  import dc_pkg::*;
#(
  parameter int unsigned width    = DEF_WIDTH,
  parameter int unsigned HOLD_W   = DEF_HOLD_W,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [(1<<width)-1:0] req,
  input  logic                  done,
  output logic [width-1:0]      a,
  output logic                  Ena,
  output logic                  Tout
);

  localparam int unsigned N = 1 << width;
  localparam logic        HAS_LIMIT = (MAX_HOLD != 0);
  // Last permitted counter value; only meaningful when HAS_LIMIT.
  localparam logic [HOLD_W-1:0] LIMIT_CNT =
    (MAX_HOLD != 0) ? HOLD_W'(MAX_HOLD - 1) : '0;

  arb_state_e        state_q, state_d;
  logic [width-1:0]  ptr_q,   ptr_d;
  logic [width-1:0]  a_q,     a_d;
  logic [HOLD_W-1:0] cnt_q,   cnt_d;
  logic              tout_q,  tout_d;

  logic [width-1:0]  pick_idx_c;
  logic              pick_any_c;
  logic              own_req_c;
  logic              limit_hit_c;

  rr_pick #(
    .width (width)
  ) u_pick (
    .req (req),
    .ptr (ptr_q),
    .idx (pick_idx_c),
    .any (pick_any_c)
  );

  assign own_req_c   = req[a_q];
  assign limit_hit_c = HAS_LIMIT && (cnt_q == LIMIT_CNT);

  // Next-state: grant from IDLE, release on done / dropped request / limit.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    tout_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any_c) begin
          state_d = GRANT;
          a_d     = pick_idx_c;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (done || !own_req_c || limit_hit_c) begin
          state_d = IDLE;
          ptr_d   = a_q + width'(1);
          // Timeout only when the limit is the sole reason for releasing.
          tout_d  = limit_hit_c && !done && own_req_c;
        end else begin
          cnt_d   = cnt_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      a_q     <= '0;
      cnt_q   <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      tout_q  <= tout_d;
    end
  end

  assign a    = a_q;
  assign Ena  = (state_q == GRANT);
  assign Tout = tout_q;

endmodule : rr_grant_idx
